// File: rtl/snake_ctrl_pkg.sv
// Shared types and constants for the snake move controller.
//   state_t : controller FSM states (3-bit)
//   dir_t   : movement direction, encoded so the opposite direction is d ^ 1
//   KEY_*   : PS/2 set-2 make codes for W/S/A/D/ENTER and the break prefix
package snake_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_MENU  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_MOVE  = 3'd2,
        ST_CHECK = 3'd3,
        ST_LOSE  = 3'd4,
        ST_WIN   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_BREAK = 8'hF0;

    // UP<->DOWN and LEFT<->RIGHT differ only in bit 0.
    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/snake_move_controller_if.sv
// Bundle of the snake controller's game-side signals.
//   master : the surrounding datapath (keyboard, move timer, LFSR, shift
//            register) - drives strobes/key/food/collision, reads the rest
//   slave  : the controller - reads the inputs, drives head, pulses, flags
interface snake_move_controller_if;

    logic        step_tick;
    logic        key_valid;
    logic [7:0]  key_code;
    logic [10:0] food_h;
    logic [10:0] food_v;
    logic        collision;

    logic [10:0] head_h;
    logic [10:0] head_v;
    logic        shift_en;
    logic        grow;
    logic        food_req;
    logic [3:0]  score;
    logic        in_menu;
    logic        in_play;
    logic        lose;
    logic        win;

    modport master (
        output step_tick, key_valid, key_code, food_h, food_v, collision,
        input  head_h, head_v, shift_en, grow, food_req, score,
               in_menu, in_play, lose, win
    );

    modport slave (
        input  step_tick, key_valid, key_code, food_h, food_v, collision,
        output head_h, head_v, shift_en, grow, food_req, score,
               in_menu, in_play, lose, win
    );

endinterface

// File: rtl/snake_key_decoder.sv
// PS/2 byte decoder for the snake controller.
// Drops the byte following a 0xF0 break prefix, maps W/S/A/D to a direction
// and ENTER to a pulse; every other byte is ignored.
//   clk, rst      : system clock, async active-high reset
//   key_valid     : key_code is valid this cycle
//   key_code      : PS/2 scancode byte
//   dir_valid     : one-cycle pulse, dir_code holds a decoded direction
//   dir_code      : decoded direction
//   enter_pulse   : one-cycle pulse on an ENTER make code
module snake_key_decoder
    import snake_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    output logic       dir_valid,
    output dir_t       dir_code,
    output logic       enter_pulse
);

    logic skip_r;
    logic dir_valid_r;
    dir_t dir_code_r;
    logic enter_pulse_r;

    // Break-code filter and make-code decode, outputs registered as pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skip_r        <= 1'b0;
            dir_valid_r   <= 1'b0;
            dir_code_r    <= DIR_RIGHT;
            enter_pulse_r <= 1'b0;
        end else begin
            dir_valid_r   <= 1'b0;
            enter_pulse_r <= 1'b0;
            if (key_valid) begin
                if (skip_r) begin
                    // Byte after 0xF0 is the released key: swallow it.
                    skip_r <= 1'b0;
                end else begin
                    case (key_code)
                        KEY_BREAK: skip_r <= 1'b1;
                        KEY_W: begin
                            dir_valid_r <= 1'b1;
                            dir_code_r  <= DIR_UP;
                        end
                        KEY_S: begin
                            dir_valid_r <= 1'b1;
                            dir_code_r  <= DIR_DOWN;
                        end
                        KEY_A: begin
                            dir_valid_r <= 1'b1;
                            dir_code_r  <= DIR_LEFT;
                        end
                        KEY_D: begin
                            dir_valid_r <= 1'b1;
                            dir_code_r  <= DIR_RIGHT;
                        end
                        KEY_ENTER: enter_pulse_r <= 1'b1;
                        default:   skip_r <= 1'b0;
                    endcase
                end
            end
        end
    end

    assign dir_valid   = dir_valid_r;
    assign dir_code    = dir_code_r;
    assign enter_pulse = enter_pulse_r;

endmodule

// File: rtl/snake_move_controller.sv
// Snake move sequencer. One game step per step_tick: commit the pending
// direction, advance the head by one grid cell (or lose on a wall), pulse
// shift_en, then resolve self-collision / food in the following cycle.
//   clk, rst : system clock, async active-high reset
//   bus      : snake_move_controller_if.slave (keys, tick, food, collision in;
//              head, shift_en/grow/food_req pulses, score, state flags out)
// Timing: a tick sampled in WAIT puts the FSM in MOVE; shift_en and the new
// head appear one cycle later (during CHECK). collision is sampled at the end
// of that CHECK cycle, and grow/food_req/LOSE/WIN appear one cycle after it.
module snake_move_controller
    import snake_ctrl_pkg::*;
#(
    parameter int unsigned GRID      = 20,
    parameter int unsigned H_MIN     = 0,
    parameter int unsigned H_MAX     = 620,
    parameter int unsigned V_MIN     = 0,
    parameter int unsigned V_MAX     = 460,
    parameter int unsigned START_H   = 320,
    parameter int unsigned START_V   = 240,
    parameter int unsigned WIN_SCORE = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    snake_move_controller_if.slave bus
);

    localparam logic [10:0] GRID_C    = 11'(GRID);
    localparam logic [11:0] GRID_W    = 12'(GRID);
    localparam logic [11:0] H_LO_W    = 12'(H_MIN + GRID);
    localparam logic [11:0] H_HI_W    = 12'(H_MAX);
    localparam logic [11:0] V_LO_W    = 12'(V_MIN + GRID);
    localparam logic [11:0] V_HI_W    = 12'(V_MAX);
    localparam logic [10:0] START_H_C = 11'(START_H);
    localparam logic [10:0] START_V_C = 11'(START_V);
    localparam logic [3:0]  WIN_C     = 4'(WIN_SCORE);

    state_t      state_r;
    dir_t        dir_r;
    dir_t        pend_dir_r;
    logic [10:0] head_h_r;
    logic [10:0] head_v_r;
    logic [3:0]  score_r;
    logic        shift_en_r;
    logic        grow_r;
    logic        food_req_r;

    logic        dir_valid_s;
    dir_t        dir_code_s;
    logic        enter_pulse_s;
    logic        wall_hit_s;
    logic [10:0] next_h_s;
    logic [10:0] next_v_s;
    logic        food_hit_s;
    logic [3:0]  score_next_s;

    snake_key_decoder u_key_decoder (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (bus.key_valid),
        .key_code    (bus.key_code),
        .dir_valid   (dir_valid_s),
        .dir_code    (dir_code_s),
        .enter_pulse (enter_pulse_s)
    );

    // Next head and wall test; bounds are checked in 12 bits before the
    // 11-bit add/subtract so a move off the left/top edge cannot wrap.
    always_comb begin
        wall_hit_s = 1'b0;
        next_h_s   = head_h_r;
        next_v_s   = head_v_r;
        case (pend_dir_r)
            DIR_UP: begin
                if ({1'b0, head_v_r} < V_LO_W) wall_hit_s = 1'b1;
                else next_v_s = head_v_r - GRID_C;
            end
            DIR_DOWN: begin
                if (({1'b0, head_v_r} + GRID_W) > V_HI_W) wall_hit_s = 1'b1;
                else next_v_s = head_v_r + GRID_C;
            end
            DIR_LEFT: begin
                if ({1'b0, head_h_r} < H_LO_W) wall_hit_s = 1'b1;
                else next_h_s = head_h_r - GRID_C;
            end
            DIR_RIGHT: begin
                if (({1'b0, head_h_r} + GRID_W) > H_HI_W) wall_hit_s = 1'b1;
                else next_h_s = head_h_r + GRID_C;
            end
            default: wall_hit_s = 1'b0;
        endcase
    end

    // Food hit and saturating score increment.
    always_comb begin
        food_hit_s = (head_h_r == bus.food_h) && (head_v_r == bus.food_v);
        if (score_r >= WIN_C) score_next_s = score_r;
        else score_next_s = score_r + 4'd1;
    end

    // Controller FSM with registered head, score, direction and pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_MENU;
            dir_r      <= DIR_RIGHT;
            pend_dir_r <= DIR_RIGHT;
            head_h_r   <= START_H_C;
            head_v_r   <= START_V_C;
            score_r    <= 4'd0;
            shift_en_r <= 1'b0;
            grow_r     <= 1'b0;
            food_req_r <= 1'b0;
        end else begin
            shift_en_r <= 1'b0;
            grow_r     <= 1'b0;
            food_req_r <= 1'b0;

            // Keys are taken in every state; a 180-degree turn is dropped.
            if (dir_valid_s && (dir_code_s != reverse_dir(dir_r))) begin
                pend_dir_r <= dir_code_s;
            end

            case (state_r)
                ST_MENU: begin
                    if (enter_pulse_s) begin
                        state_r    <= ST_WAIT;
                        food_req_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (bus.step_tick) state_r <= ST_MOVE;
                end
                ST_MOVE: begin
                    dir_r <= pend_dir_r;
                    if (wall_hit_s) begin
                        state_r <= ST_LOSE;
                    end else begin
                        head_h_r   <= next_h_s;
                        head_v_r   <= next_v_s;
                        shift_en_r <= 1'b1;
                        state_r    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (bus.collision) begin
                        state_r <= ST_LOSE;
                    end else if (food_hit_s) begin
                        grow_r  <= 1'b1;
                        score_r <= score_next_s;
                        if (score_next_s == WIN_C) begin
                            state_r <= ST_WIN;
                        end else begin
                            food_req_r <= 1'b1;
                            state_r    <= ST_WAIT;
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_LOSE, ST_WIN: begin
                    // Overrides any same-cycle pend_dir update above.
                    if (enter_pulse_s) begin
                        state_r    <= ST_MENU;
                        dir_r      <= DIR_RIGHT;
                        pend_dir_r <= DIR_RIGHT;
                        head_h_r   <= START_H_C;
                        head_v_r   <= START_V_C;
                        score_r    <= 4'd0;
                    end
                end
                default: state_r <= ST_MENU;
            endcase
        end
    end

    assign bus.head_h   = head_h_r;
    assign bus.head_v   = head_v_r;
    assign bus.shift_en = shift_en_r;
    assign bus.grow     = grow_r;
    assign bus.food_req = food_req_r;
    assign bus.score    = score_r;
    assign bus.in_menu  = (state_r == ST_MENU);
    assign bus.in_play  = (state_r == ST_WAIT) || (state_r == ST_MOVE) || (state_r == ST_CHECK);
    assign bus.lose     = (state_r == ST_LOSE);
    assign bus.win      = (state_r == ST_WIN);

endmodule

// File: tb/tb_snake_move_controller.sv
// Scoreboard bench for snake_move_controller. The driver feeds keys, ticks,
// collisions and food to a game-level reference model that pushes the output
// events it predicts (with the cycle they must appear in); a monitor pops
// and compares whenever the DUT shows a pulse or a state-flag change.
module tb_snake_move_controller;
    import snake_ctrl_pkg::*;

    localparam bit [3:0] F_MENU = 4'b1000;
    localparam bit [3:0] F_PLAY = 4'b0100;
    localparam bit [3:0] F_LOSE = 4'b0010;
    localparam bit [3:0] F_WIN  = 4'b0001;
    localparam int M_MENU = 0, M_PLAY = 1, M_LOSE = 2, M_WIN = 3;

    typedef struct {
        int     cyc;
        int     hh;
        int     hv;
        bit     sh;
        bit     gr;
        bit     fr;
        int     sc;
        bit [3:0] fl;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    rec_t exp_q[$];

    // Reference model state, in game terms (pixels, direction indices).
    int m_mode, m_h, m_v, m_dir, m_pend, m_score, m_food_h, m_food_v;
    bit m_skip, m_need_food;
    bit auto_food = 1'b0;
    int dx[4]  = '{0, 0, -20, 20};
    int dy[4]  = '{-20, 20, 0, 0};
    int opp[4] = '{1, 0, 3, 2};
    logic [7:0] dir_keys[4] = '{KEY_W, KEY_S, KEY_A, KEY_D};

    snake_move_controller_if bus();

    snake_move_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function void push(int c, int h, int v, bit sh, bit gr, bit fr, int sc, bit [3:0] fl);
        rec_t r;
        r.cyc = c; r.hh = h; r.hv = v; r.sh = sh; r.gr = gr; r.fr = fr; r.sc = sc; r.fl = fl;
        exp_q.push_back(r);
    endfunction

    function void model_reset();
        m_mode = M_MENU; m_h = 320; m_v = 240; m_dir = 3; m_pend = 3;
        m_score = 0; m_skip = 1'b0; m_need_food = 1'b0;
    endfunction

    function void model_key(int k, logic [7:0] code);
        int d;
        d = -1;
        if (m_skip) begin
            m_skip = 1'b0;
        end else if (code == KEY_BREAK) begin
            m_skip = 1'b1;
        end else if (code == KEY_ENTER) begin
            if (m_mode == M_MENU) begin
                m_mode = M_PLAY;
                m_need_food = 1'b1;
                push(k + 2, m_h, m_v, 1'b0, 1'b0, 1'b1, m_score, F_PLAY);
            end else if (m_mode == M_LOSE || m_mode == M_WIN) begin
                model_reset();
                push(k + 2, m_h, m_v, 1'b0, 1'b0, 1'b0, 0, F_MENU);
            end
        end else begin
            for (int i = 0; i < 4; i++) if (code == dir_keys[i]) d = i;
            if (d >= 0 && d != opp[m_dir]) m_pend = d;
        end
    endfunction

    function void model_tick(int k, bit coll);
        int nh, nv;
        if (m_mode != M_PLAY) return;
        m_dir = m_pend;
        nh = m_h + dx[m_dir];
        nv = m_v + dy[m_dir];
        if (nh < 0 || nh > 620 || nv < 0 || nv > 460) begin
            m_mode = M_LOSE;
            push(k + 2, m_h, m_v, 1'b0, 1'b0, 1'b0, m_score, F_LOSE);
        end else begin
            m_h = nh; m_v = nv;
            push(k + 2, m_h, m_v, 1'b1, 1'b0, 1'b0, m_score, F_PLAY);
            if (coll) begin
                m_mode = M_LOSE;
                push(k + 3, m_h, m_v, 1'b0, 1'b0, 1'b0, m_score, F_LOSE);
            end else if (m_h == m_food_h && m_v == m_food_v) begin
                m_score = m_score + 1;
                if (m_score == 9) begin
                    m_mode = M_WIN;
                    push(k + 3, m_h, m_v, 1'b0, 1'b1, 1'b0, m_score, F_WIN);
                end else begin
                    m_need_food = 1'b1;
                    push(k + 3, m_h, m_v, 1'b0, 1'b1, 1'b1, m_score, F_PLAY);
                end
            end
        end
    endfunction

    task automatic send_key(input logic [7:0] code);
        int k;
        @(negedge clk);
        bus.key_code  = code;
        bus.key_valid = 1'b1;
        k = cyc;
        @(negedge clk);
        bus.key_valid = 1'b0;
        model_key(k, code);
        repeat (3) @(negedge clk);
    endtask

    // dbl holds the tick into the MOVE cycle, where it must be dropped.
    task automatic send_tick(input bit coll, input bit dbl);
        int k;
        @(negedge clk);
        bus.step_tick = 1'b1;
        k = cyc;
        model_tick(k, coll);
        @(negedge clk);
        if (!dbl) bus.step_tick = 1'b0;
        @(negedge clk);
        bus.step_tick = 1'b0;
        bus.collision = coll;
        @(negedge clk);
        bus.collision = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_food(input int h, input int v);
        @(negedge clk);
        bus.food_h = 11'(h);
        bus.food_v = 11'(v);
        m_food_h = h; m_food_v = v;
        m_need_food = 1'b0;
    endtask

    task automatic pick_food();
        int fh, fv;
        fh = -1; fv = 0;
        if ($urandom_range(0, 99) < 60) begin
            fh = m_h + dx[m_pend];
            fv = m_v + dy[m_pend];
        end
        if (fh < 0 || fh > 620 || fv < 0 || fv > 460) begin
            fh = 20 * int'($urandom_range(0, 31));
            fv = 20 * int'($urandom_range(0, 23));
        end
        set_food(fh, fv);
    endtask

    task automatic check_reset(input string name);
        bit [3:0] fl;
        fl = {bus.in_menu, bus.in_play, bus.lose, bus.win};
        n_checks++;
        if (bus.head_h !== 11'd320 || bus.head_v !== 11'd240 || bus.shift_en !== 1'b0 ||
            bus.grow !== 1'b0 || bus.food_req !== 1'b0 || bus.score !== 4'd0 || fl !== F_MENU) begin
            n_fail++;
            $display("FAIL %s: got head=(%0d,%0d) sh=%b gr=%b fr=%b score=%0d flags=%b, expected head=(320,240) sh=0 gr=0 fr=0 score=0 flags=%b",
                     name, bus.head_h, bus.head_v, bus.shift_en, bus.grow, bus.food_req, bus.score, fl, F_MENU);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("reset_state");
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: one scoreboard comparison per observed output event.
    initial begin
        bit [3:0] prev_fl, fl;
        rec_t e;
        prev_fl = F_MENU;
        forever begin
            @(negedge clk);
            fl = {bus.in_menu, bus.in_play, bus.lose, bus.win};
            if (rst) begin
                prev_fl = F_MENU;
            end else begin
                if (bus.shift_en || bus.grow || bus.food_req || fl != prev_fl) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_event cyc=%0d: got head=(%0d,%0d) sh=%b gr=%b fr=%b score=%0d flags=%b, expected no event",
                                 cyc, bus.head_h, bus.head_v, bus.shift_en, bus.grow, bus.food_req, bus.score, fl);
                    end else begin
                        e = exp_q.pop_front();
                        if (cyc != e.cyc || bus.head_h !== 11'(e.hh) || bus.head_v !== 11'(e.hv) ||
                            bus.shift_en !== e.sh || bus.grow !== e.gr || bus.food_req !== e.fr ||
                            bus.score !== 4'(e.sc) || fl !== e.fl) begin
                            n_fail++;
                            $display("FAIL event: got cyc=%0d head=(%0d,%0d) sh=%b gr=%b fr=%b score=%0d flags=%b, expected cyc=%0d head=(%0d,%0d) sh=%b gr=%b fr=%b score=%0d flags=%b",
                                     cyc, bus.head_h, bus.head_v, bus.shift_en, bus.grow, bus.food_req, bus.score, fl,
                                     e.cyc, e.hh, e.hv, e.sh, e.gr, e.fr, e.sc, e.fl);
                        end
                    end
                end
                prev_fl = fl;
            end
        end
    end

    // Stimulus: directed game scenarios, then a randomized session.
    initial begin
        int r, k;
        logic [7:0] code;
        bus.step_tick = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 8'h00;
        bus.collision = 1'b0;
        bus.food_h    = 11'd340;
        bus.food_v    = 11'd240;
        m_food_h = 340; m_food_v = 240;
        model_reset();
        apply_reset();

        // Start, first move eats food at (340,240).
        send_key(KEY_ENTER);
        send_tick(1'b0, 1'b0);
        set_food(600, 400);
        // Reverse turn rejected, then break-coded UP ignored.
        send_key(KEY_A);
        send_tick(1'b0, 1'b0);
        send_key(KEY_BREAK);
        send_key(KEY_W);
        send_tick(1'b0, 1'b0);
        // Collision and food in the same CHECK: collision wins.
        set_food(400, 240);
        send_tick(1'b1, 1'b0);

        // Walk to (0,100) heading left, then hit the wall.
        send_key(KEY_ENTER);
        send_key(KEY_ENTER);
        set_food(600, 0);
        send_key(KEY_W);
        repeat (7) send_tick(1'b0, 1'b0);
        send_key(KEY_A);
        repeat (16) send_tick(1'b0, 1'b0);
        send_tick(1'b0, 1'b0);

        // Eat nine times in a row to win, then return to the menu.
        send_key(KEY_ENTER);
        send_key(KEY_ENTER);
        for (int i = 0; i < 9; i++) begin
            set_food(m_h + dx[m_pend], m_v + dy[m_pend]);
            send_tick(1'b0, 1'b0);
        end
        send_tick(1'b0, 1'b0);
        send_key(KEY_ENTER);

        // Randomized session.
        auto_food = 1'b1;
        for (int n = 0; n < 1200; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 45) begin
                send_tick($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 10);
            end else if (r < 75) begin
                send_key(dir_keys[$urandom_range(0, 3)]);
            end else if (r < 82) begin
                send_key(KEY_BREAK);
                send_key(dir_keys[$urandom_range(0, 3)]);
            end else if (r < 88) begin
                code = 8'($urandom_range(0, 255));
                if (code inside {KEY_W, KEY_S, KEY_A, KEY_D, KEY_ENTER, KEY_BREAK}) code = 8'h11;
                send_key(code);
            end else if (r < 94) begin
                send_key(KEY_ENTER);
            end else begin
                repeat (2) @(negedge clk);
            end
            if (auto_food && m_need_food) pick_food();
        end

        // Asynchronous reset while the FSM sits in CHECK.
        auto_food = 1'b0;
        apply_reset();
        send_key(KEY_ENTER);
        set_food(0, 0);
        @(negedge clk);
        bus.step_tick = 1'b1;
        k = cyc;
        model_tick(k, 1'b0);
        @(negedge clk);
        bus.step_tick = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset("reset_in_check");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (6) @(negedge clk);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: got %0d undelivered, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
